override_pc_injector: RTL and testbench
=======================================

Name: override_pc_injector

Overview:
- Sits directly upstream of the token-ring topology and drives its override channel (valid/ready/data/latency).
- On each new character it injects one start-PC token per enabled character-compare (CC) slot into the ring, then waits for the ring to drain that character.
- Reports per-character completion to the controller.
- Is the only source of fresh threads entering the basic-block ring.

Parameters:
- PC_WIDTH, 8, width of program counter in a token
- CC_ID_BITS, 1, log2 of CC slots; slots = 2**CC_ID_BITS
- START_PC, 0, PC injected for every new thread (truncated to PC_WIDTH)
- LATENCY_COUNT_WIDTH, 8, width of override latency field

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- new_char  in  1  one-cycle pulse: cur_window_* hold a new character
- cur_window_enable  in  2**CC_ID_BITS  per-slot enable, sampled on new_char
- cur_window_end_of_s  in  2**CC_ID_BITS  per-slot end-of-string, sampled on new_char
- any_bb_running  in  1  ring still holds tokens
- elaborating_chars  in  2**CC_ID_BITS  per-slot busy from ring
- ovr_valid  out  1  override token valid
- ovr_data  out  PC_WIDTH+CC_ID_BITS  token {pc, cc_id}, cc_id in LSBs
- ovr_ready  in  1  ring arbiter accepts token
- ovr_latency  in  LATENCY_COUNT_WIDTH  ring latency, informational only
- busy  out  1  high from new_char accepted until DONE
- char_done  out  1  one-cycle pulse when current character fully processed
- injected_count  out  CC_ID_BITS+1  tokens injected for current character

Behaviour:
- Clocking: one clock, clk; rst is synchronous, active-high.
- Reset values: state=IDLE, ovr_valid=0, ovr_data=0, busy=0, char_done=0, injected_count=0, pending mask=0.
- FSM states: IDLE, LOAD, INJECT, DRAIN, DONE.
- IDLE:
  - On new_char, latch pending = cur_window_enable & ~cur_window_end_of_s.
  - Clear injected_count, assert busy next cycle, go to LOAD.
  - new_char in any other state is ignored; the controller guarantees spacing via busy.
- LOAD:
  - pending==0 -> DONE.
  - Else select lowest set bit k, drive ovr_valid=1 and ovr_data={START_PC,k}, go to INJECT.
- INJECT, handshake per cycle:
  - Transfer occurs when ovr_valid & ovr_ready.
  - While not accepted, ovr_valid and ovr_data hold stable. No retraction, no data change.
  - On transfer, clear bit k and increment injected_count (saturating is unnecessary; max = slots).
  - If remaining pending != 0, present the next-lowest slot in the same cycle. Back-to-back tokens: one per cycle under continuous ready.
  - Else drop ovr_valid and go to DRAIN.
- DRAIN:
  - Wait until any_bb_running==0 and elaborating_chars==0 for 2 consecutive cycles. This covers the token in flight on the override arbiter.
  - Then go to DONE.
- DONE: char_done=1 for exactly one cycle, busy=0, return to IDLE.
- Latency (single slot, ready=1, ring idle): new_char at cycle 0 -> ovr_valid at cycle 2 -> DRAIN at 3 -> char_done at 5 minimum.
- Boundaries:
  - All slots disabled or at end-of-string: no ovr_valid, char_done 2 cycles after new_char.
  - ovr_ready low indefinitely: stall in INJECT, busy held.
  - rst mid-INJECT: ovr_valid low next cycle, pending cleared, no partial token.
  - ovr_latency is unused for control; it is ignored.

Optional Feature:
- Macro: OVERRIDE_PC_INJECTOR_STATS_EN.
- When defined:
  - Adds output stall_cycles (16 bits) counting cycles with ovr_valid & ~ovr_ready, saturating at 16'hFFFF.
  - Adds output char_count (16 bits) incremented on each char_done, wrapping.
  - Both reset to 0 on rst.
- When undefined: ports and counters are absent; core behaviour is identical.

Test Plan:
- CC_ID_BITS=1, enable=2'b11, eos=00, ready=1, ring idle -> ovr_data {0,0} then {0,1} on consecutive cycles, injected_count=2, one char_done pulse.
- enable=2'b10, eos=00 -> single token ovr_data={START_PC,1}, slot 0 never sent.
- enable=2'b11, eos=2'b11 -> no ovr_valid, char_done exactly 2 cycles after new_char.
- ready held low 5 cycles then high -> ovr_valid/ovr_data stable throughout, single transfer, no duplicate.
- any_bb_running held high 10 cycles after last injection -> char_done only after it falls plus 2 idle cycles.
- rst asserted during INJECT with ready=0 -> next cycle ovr_valid=0, busy=0; subsequent new_char processed normally.

Source files
------------

// File: rtl/override_pc_injector.sv
// Override-channel injector: seeds one start-PC token per enabled CC slot into the
// token ring per character, then waits for the ring to drain. Optional stats: OVERRIDE_PC_INJECTOR_STATS_EN.
module override_pc_injector #(
  parameter int PC_WIDTH            = 8,
  parameter int CC_ID_BITS          = 1,
  parameter int START_PC            = 0,
  parameter int LATENCY_COUNT_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           new_char,
  input  logic [2**CC_ID_BITS-1:0]       cur_window_enable,
  input  logic [2**CC_ID_BITS-1:0]       cur_window_end_of_s,
  input  logic                           any_bb_running,
  input  logic [2**CC_ID_BITS-1:0]       elaborating_chars,
  output logic                           ovr_valid,
  output logic [PC_WIDTH+CC_ID_BITS-1:0] ovr_data,
  input  logic                           ovr_ready,
  input  logic [LATENCY_COUNT_WIDTH-1:0] ovr_latency,
  output logic                           busy,
  output logic                           char_done,
  output logic [CC_ID_BITS:0]            injected_count
`ifdef OVERRIDE_PC_INJECTOR_STATS_EN
  ,
  output logic [15:0]                    stall_cycles,
  output logic [15:0]                    char_count
`endif
);

  localparam int SLOTS = 2**CC_ID_BITS;
  localparam int CNT_W = CC_ID_BITS + 1;
  localparam int DATA_W = PC_WIDTH + CC_ID_BITS;
  localparam logic [PC_WIDTH-1:0] START_PC_T = PC_WIDTH'(START_PC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_INJECT,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [SLOTS-1:0]    pending_q, pending_d;
  logic                ovr_valid_q, ovr_valid_d;
  logic [DATA_W-1:0]   ovr_data_q, ovr_data_d;
  logic                busy_q, busy_d;
  logic                char_done_q, char_done_d;
  logic [CNT_W-1:0]    injected_count_q, injected_count_d;
  logic                drain_cnt_q, drain_cnt_d;

  logic [CC_ID_BITS-1:0] cur_k;
  logic [SLOTS-1:0]      pend_after;
  logic                  ring_idle;
  logic                  xfer;

  // The ring's latency is informational; control never depends on it.
  logic unused_latency;
  assign unused_latency = ^ovr_latency;

  function automatic logic [CC_ID_BITS-1:0] lowest_idx(input logic [SLOTS-1:0] m);
    lowest_idx = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (m[i]) lowest_idx = CC_ID_BITS'(i);
    end
  endfunction

  assign cur_k      = ovr_data_q[CC_ID_BITS-1:0];
  assign pend_after = pending_q & ~(SLOTS'(1) << cur_k);
  assign ring_idle  = ~any_bb_running & ~(|elaborating_chars);
  assign xfer       = ovr_valid_q & ovr_ready;

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case infers a latch.
    state_d          = state_q;
    pending_d        = pending_q;
    ovr_valid_d      = ovr_valid_q;
    ovr_data_d       = ovr_data_q;
    busy_d           = busy_q;
    char_done_d      = 1'b0;
    injected_count_d = injected_count_q;
    drain_cnt_d      = drain_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (new_char) begin
          pending_d        = cur_window_enable & ~cur_window_end_of_s;
          injected_count_d = '0;
          busy_d           = 1'b1;
          state_d          = S_LOAD;
        end
      end

      S_LOAD: begin
        if (pending_q == '0) begin
          busy_d      = 1'b0;
          char_done_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          ovr_valid_d = 1'b1;
          ovr_data_d  = {START_PC_T, lowest_idx(pending_q)};
          state_d     = S_INJECT;
        end
      end

      // Valid/data only change on a transfer, so a stalled token is never retracted.
      S_INJECT: begin
        if (xfer) begin
          pending_d        = pend_after;
          injected_count_d = injected_count_q + CNT_W'(1);
          if (pend_after != '0) begin
            ovr_data_d = {START_PC_T, lowest_idx(pend_after)};
          end else begin
            ovr_valid_d = 1'b0;
            drain_cnt_d = 1'b0;
            state_d     = S_DRAIN;
          end
        end
      end

      // Two consecutive idle cycles cover the token still in the override arbiter.
      S_DRAIN: begin
        if (ring_idle) begin
          if (drain_cnt_q) begin
            busy_d      = 1'b0;
            char_done_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            drain_cnt_d = 1'b1;
          end
        end else begin
          drain_cnt_d = 1'b0;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef OVERRIDE_PC_INJECTOR_STATS_EN
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] char_count_q, char_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    char_count_d   = char_count_q;
    if (ovr_valid_q && !ovr_ready && stall_cycles_q != 16'hFFFF) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
    if (char_done_q) begin
      char_count_d = char_count_q + 16'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign char_count   = char_count_q;
`endif

  // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      pending_q        <= '0;
      ovr_valid_q      <= 1'b0;
      ovr_data_q       <= '0;
      busy_q           <= 1'b0;
      char_done_q      <= 1'b0;
      injected_count_q <= '0;
      drain_cnt_q      <= 1'b0;
`ifdef OVERRIDE_PC_INJECTOR_STATS_EN
      stall_cycles_q   <= '0;
      char_count_q     <= '0;
`endif
    end else begin
      state_q          <= state_d;
      pending_q        <= pending_d;
      ovr_valid_q      <= ovr_valid_d;
      ovr_data_q       <= ovr_data_d;
      busy_q           <= busy_d;
      char_done_q      <= char_done_d;
      injected_count_q <= injected_count_d;
      drain_cnt_q      <= drain_cnt_d;
`ifdef OVERRIDE_PC_INJECTOR_STATS_EN
      stall_cycles_q   <= stall_cycles_d;
      char_count_q     <= char_count_d;
`endif
    end
  end

  assign ovr_valid      = ovr_valid_q;
  assign ovr_data       = ovr_data_q;
  assign busy           = busy_q;
  assign char_done      = char_done_q;
  assign injected_count = injected_count_q;

endmodule

// File: tb/tb_override_pc_injector.sv
// Directed bench for override_pc_injector (default parameters): a vector table of
// per-character scenarios plus a hand-written reset-during-injection sequence.
module tb_override_pc_injector;

  logic       clk = 1'b0;
  logic       rst;
  logic       new_char;
  logic [1:0] cur_window_enable;
  logic [1:0] cur_window_end_of_s;
  logic       any_bb_running;
  logic [1:0] elaborating_chars;
  logic       ovr_valid;
  logic [8:0] ovr_data;
  logic       ovr_ready;
  logic [7:0] ovr_latency;
  logic       busy;
  logic       char_done;
  logic [1:0] injected_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  override_pc_injector dut (
    .clk                 (clk),
    .rst                 (rst),
    .new_char            (new_char),
    .cur_window_enable   (cur_window_enable),
    .cur_window_end_of_s (cur_window_end_of_s),
    .any_bb_running      (any_bb_running),
    .elaborating_chars   (elaborating_chars),
    .ovr_valid           (ovr_valid),
    .ovr_data            (ovr_data),
    .ovr_ready           (ovr_ready),
    .ovr_latency         (ovr_latency),
    .busy                (busy),
    .char_done           (char_done),
    .injected_count      (injected_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Cycle 0 is the cycle new_char is high; inputs for cycle c are driven and
  // outputs sampled at the falling edge inside cycle c.
  task automatic run_char(
    input  logic [1:0] en,
    input  logic [1:0] eos,
    input  int         ready_low,
    input  int         bb_until,
    input  int         elab_at,
    output int         ntok,
    output logic [8:0] tok0,
    output logic [8:0] tok1,
    output int         first_c,
    output int         done_c,
    output int         pulses,
    output bit         unstable,
    output bit         busy1,
    output bit         busy_at_done
  );
    logic       pv, pr;
    logic [8:0] pd;
    ntok = 0; tok0 = '0; tok1 = '0; first_c = -1; done_c = -1; pulses = 0;
    unstable = 1'b0; busy1 = 1'b0; busy_at_done = 1'b1;
    pv = 1'b0; pr = 1'b0; pd = '0;
    cur_window_enable   = en;
    cur_window_end_of_s = eos;
    new_char            = 1'b1;
    ovr_ready           = (ready_low < 0);
    any_bb_running      = (bb_until >= 0);
    elaborating_chars   = 2'b00;
    @(negedge clk);
    new_char = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      ovr_ready         = (c > ready_low);
      any_bb_running    = (c <= bb_until);
      elaborating_chars = (c == elab_at) ? 2'b01 : 2'b00;
      if (pv && !pr && (!ovr_valid || ovr_data !== pd)) unstable = 1'b1;
      if (c == 1) busy1 = busy;
      if (ovr_valid && ovr_ready) begin
        if (ntok == 0) begin
          tok0    = ovr_data;
          first_c = c;
        end else if (ntok == 1) begin
          tok1 = ovr_data;
        end
        ntok++;
      end
      if (char_done) begin
        pulses++;
        if (done_c < 0) begin
          done_c       = c;
          busy_at_done = busy;
        end
      end
      pv = ovr_valid; pr = ovr_ready; pd = ovr_data;
      @(negedge clk);
    end
    ovr_ready         = 1'b1;
    any_bb_running    = 1'b0;
    elaborating_chars = 2'b00;
  endtask

  typedef struct {
    string      name;
    logic [1:0] en;
    logic [1:0] eos;
    int         ready_low;
    int         bb_until;
    int         elab_at;
    int         exp_ntok;
    logic [8:0] exp_tok0;
    logic [8:0] exp_tok1;
    int         exp_first;
    int         exp_done;
  } vec_t;

  vec_t vecs[9];

  int         ntok, first_c, done_c, pulses;
  logic [8:0] tok0, tok1;
  bit         unstable, busy1, busy_at_done;

  initial begin
    vecs[0] = '{"two_slots",     2'b11, 2'b00, 0, 0,  0,  2, 9'h000, 9'h001, 2, 6};
    vecs[1] = '{"slot1_only",    2'b10, 2'b00, 0, 0,  0,  1, 9'h001, 9'h000, 2, 5};
    vecs[2] = '{"slot0_only",    2'b01, 2'b00, 0, 0,  0,  1, 9'h000, 9'h000, 2, 5};
    vecs[3] = '{"all_eos",       2'b11, 2'b11, 0, 0,  0,  0, 9'h000, 9'h000, -1, 2};
    vecs[4] = '{"none_enabled",  2'b00, 2'b00, 0, 0,  0,  0, 9'h000, 9'h000, -1, 2};
    vecs[5] = '{"eos_slot0",     2'b11, 2'b01, 0, 0,  0,  1, 9'h001, 9'h000, 2, 5};
    vecs[6] = '{"ready_stall",   2'b01, 2'b00, 6, 0,  0,  1, 9'h000, 9'h000, 7, 10};
    vecs[7] = '{"bb_drain",      2'b01, 2'b00, 0, 12, 0,  1, 9'h000, 9'h000, 2, 15};
    vecs[8] = '{"elab_glitch",   2'b11, 2'b00, 6, 12, 14, 2, 9'h000, 9'h001, 7, 17};

    rst = 1'b1; new_char = 1'b0; cur_window_enable = '0; cur_window_end_of_s = '0;
    any_bb_running = 1'b0; elaborating_chars = '0; ovr_ready = 1'b1; ovr_latency = 8'd3;
    repeat (3) @(negedge clk);
    check("reset_ovr_valid", 32'(ovr_valid), 32'd0);
    check("reset_ovr_data", 32'(ovr_data), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_char_done", 32'(char_done), 32'd0);
    check("reset_injected_count", 32'(injected_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_char(vecs[i].en, vecs[i].eos, vecs[i].ready_low, vecs[i].bb_until, vecs[i].elab_at,
               ntok, tok0, tok1, first_c, done_c, pulses, unstable, busy1, busy_at_done);
      check({vecs[i].name, "_ntok"}, 32'(ntok), 32'(vecs[i].exp_ntok));
      check({vecs[i].name, "_tok0"}, 32'(tok0), 32'(vecs[i].exp_tok0));
      check({vecs[i].name, "_tok1"}, 32'(tok1), 32'(vecs[i].exp_tok1));
      check({vecs[i].name, "_first_cycle"}, 32'(first_c), 32'(vecs[i].exp_first));
      check({vecs[i].name, "_done_cycle"}, 32'(done_c), 32'(vecs[i].exp_done));
      check({vecs[i].name, "_done_pulses"}, 32'(pulses), 32'd1);
      check({vecs[i].name, "_stable"}, 32'(unstable), 32'd0);
      check({vecs[i].name, "_busy_c1"}, 32'(busy1), 32'd1);
      check({vecs[i].name, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
      check({vecs[i].name, "_injected_count"}, 32'(injected_count), 32'(vecs[i].exp_ntok));
    end

    // Reset while a token is stalled: it must vanish, and the next character starts clean.
    cur_window_enable = 2'b11; cur_window_end_of_s = 2'b00; ovr_ready = 1'b0;
    new_char = 1'b1;
    @(negedge clk);
    new_char = 1'b0;
    @(negedge clk);
    check("rst_seq_valid_before", 32'(ovr_valid), 32'd1);
    check("rst_seq_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_seq_valid_after", 32'(ovr_valid), 32'd0);
    check("rst_seq_busy_after", 32'(busy), 32'd0);
    check("rst_seq_count_after", 32'(injected_count), 32'd0);
    ovr_ready = 1'b1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      if (ovr_valid || char_done) pulses++;
      @(negedge clk);
    end
    check("rst_seq_quiet_after", 32'(pulses), 32'd0);
    run_char(2'b10, 2'b00, 0, 0, 0,
             ntok, tok0, tok1, first_c, done_c, pulses, unstable, busy1, busy_at_done);
    check("rst_seq_next_ntok", 32'(ntok), 32'd1);
    check("rst_seq_next_tok0", 32'(tok0), 32'h001);
    check("rst_seq_next_done", 32'(done_c), 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
